npu_reg_ctrl: RTL and testbench
===============================

Name: npu_reg_ctrl

Overview:
APB-style register front-end for the NPU control unit, sitting directly upstream of it on the host side. It turns host register writes into the control unit's start/soft_reset pulses and its activation_type/matrix_size configuration. It captures the control unit's busy/done/error/current_state outputs into readable status, maskable W1C interrupt status, and run/cycle performance counters. It drives a single level interrupt to the host.

Parameters:
MATRIX_SIZE, 8, reset value of CONFIG.MATRIX_SIZE; must match the control unit.
ADDR_W, 8, APB address width.

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
psel  in  1  APB select
penable  in  1  APB enable (access phase)
pwrite  in  1  1 = write
paddr  in  ADDR_W  byte address; bits[1:0] ignored
pwdata  in  32  write data
prdata  out  32  read data
pready  out  1  transfer complete
pslverr  out  1  transfer error
start  out  1  one-cycle start pulse to control unit
soft_reset  out  1  one-cycle soft reset pulse to control unit
activation_type  out  2  activation select
matrix_size  out  8  matrix size configuration
busy  in  1  control unit busy
done  in  1  control unit done pulse
error  in  1  control unit error level
current_state  in  3  control unit state, debug
irq  out  1  host interrupt, level

Behaviour:
- Clock and reset: single clock clk; rst_n is synchronous, active-low, sampled on posedge clk.
- Reset values: prdata=0, pready=0, pslverr=0, start=0, soft_reset=0, activation_type=0, matrix_size=MATRIX_SIZE, irq=0. All registers and counters reset to 0, except CONFIG.
- APB protocol, zero wait states:
  - Setup phase (psel & !penable): prdata is registered from the addressed register.
  - Access phase (psel & penable): pready=1 for exactly that cycle; write side-effects commit at the edge ending the access phase.
  - Outside access, pready=0 and pslverr=0.
- Register map:
  - 0x00 CTRL (WO, reads 0): bit0 START, bit1 SOFT_RESET.
  - 0x04 CONFIG (RW): [7:0] MATRIX_SIZE, [9:8] ACT_TYPE. Drives matrix_size and activation_type directly.
  - 0x08 STATUS (RO): bit0 busy, bit1 done_seen, bit2 error, [6:4] current_state. Inputs are sampled one cycle (registered).
  - 0x0C INT_EN (RW): bit0 done_en, bit1 err_en, bit2 ovr_en.
  - 0x10 INT_STAT (RW1C): bit0 done, bit1 err, bit2 start_overrun.
  - 0x14 CYCLE_CNT (RO): 32-bit count of cycles with busy=1. Cleared on each issued start; saturates at 0xFFFFFFFF.
  - 0x18 RUN_CNT (RO): 16-bit count of done pulses; saturates at 0xFFFF.
- Unmapped address, or write to an RO register: pslverr=1 in the access phase, no side-effect, read data 0.
- START write with busy=0: start=1 for exactly the one cycle after the commit edge.
- START write with busy=1: no pulse; INT_STAT.start_overrun set; pslverr=0.
- SOFT_RESET write: soft_reset=1 for one cycle. The same edge clears INT_STAT, done_seen, CYCLE_CNT and the irq register. CONFIG, INT_EN and RUN_CNT are kept.
- START and SOFT_RESET in the same write: soft_reset only, no start.
- Done event: done=1 (pulse) sets INT_STAT.done and done_seen, and increments RUN_CNT. done_seen clears on the next issued start.
- Error event: rising edge of error, detected with a registered copy of error. Sets INT_STAT.err.
- Simultaneous hardware set and W1C clear of the same bit: set wins.
- irq is registered: irq <= |(INT_STAT & INT_EN), giving one cycle of latency after the status change. Writes to INT_EN take effect on irq the following cycle.
- Reset mid-transfer: the transfer is abandoned and all outputs return to reset values; the host must reissue it.

Test Plan:
- Reset, then read 0x04 -> prdata=0x00000008; read 0x00 -> 0; irq=0; start=0.
- Write 0x04=0x205, then write 0x00=0x1 with busy=0 -> activation_type=2, matrix_size=5; start high exactly 1 cycle after the access edge; CYCLE_CNT=0.
- Hold busy=1 for 37 cycles, then pulse done; INT_EN=0x1 -> CYCLE_CNT=37, RUN_CNT=1, INT_STAT=0x1, irq=1 one cycle after done. Write 0x10=0x1 -> irq=0.
- Write 0x00=0x1 while busy=1 -> no start pulse, INT_STAT=0x4. Pulse done on the same cycle as a W1C of bit0 -> bit0 remains 1.
- Raise error level with err_en=1 -> INT_STAT.err=1, irq=1. Write 0x00=0x3 -> soft_reset 1 cycle, start=0, INT_STAT=0, CONFIG unchanged.
- Read 0x3C, and write 0x08 -> pslverr=1, pready=1, prdata=0, no register change.

Source files
------------

// File: rtl/npu_reg_ctrl.sv
// npu_reg_ctrl: APB register front-end for the NPU control unit (control pulses, config, status, irq, perf counters)
module npu_reg_ctrl #(
    parameter int MATRIX_SIZE = 8,
    parameter int ADDR_W      = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [ADDR_W-1:0] paddr,
    input  logic [31:0]       pwdata,
    output logic [31:0]       prdata,
    output logic              pready,
    output logic              pslverr,
    output logic              start,
    output logic              soft_reset,
    output logic [1:0]        activation_type,
    output logic [7:0]        matrix_size,
    input  logic              busy,
    input  logic              done,
    input  logic              error,
    input  logic [2:0]        current_state,
    output logic              irq
);
    logic [2:0]  sel;
    logic        mapped, ro, bad, setup, wr, wr_ctrl, soft_wr, st_req, st_issue, ovr, err_rise;
    logic        busy_q, err_q, done_seen;
    logic [2:0]  cs_q, int_en, int_stat, w1c;
    logic [31:0] cyc_cnt, rd;
    logic [15:0] run_cnt;
    logic        unused;
    assign unused   = ^{pwdata[31:10], paddr[1:0]};
    assign sel      = paddr[4:2];
    assign mapped   = ~|paddr[ADDR_W-1:5] && sel != 3'd7;
    assign ro       = sel == 3'd2 || sel == 3'd5 || sel == 3'd6;
    assign bad      = !mapped || (pwrite && ro);
    assign setup    = psel && !penable;
    assign wr       = psel && penable && pwrite && !bad;
    assign wr_ctrl  = wr && sel == 3'd0;
    assign soft_wr  = wr_ctrl && pwdata[1];
    assign st_req   = wr_ctrl && pwdata[0] && !pwdata[1];
    assign st_issue = st_req && !busy;
    assign ovr      = st_req && busy;
    assign err_rise = error && !err_q;
    assign w1c      = (wr && sel == 3'd4) ? pwdata[2:0] : 3'b0;
    // Read mux for the addressed register; errors and CTRL read as zero
    always_comb begin
        rd = bad              ? 32'h0 :
             sel == 3'd1      ? {22'h0, activation_type, matrix_size} :
             sel == 3'd2      ? {25'h0, cs_q, 1'b0, err_q, done_seen, busy_q} :
             sel == 3'd3      ? {29'h0, int_en} :
             sel == 3'd4      ? {29'h0, int_stat} :
             sel == 3'd5      ? cyc_cnt :
             sel == 3'd6      ? {16'h0, run_cnt} : 32'h0;
    end
    // APB response, control pulses, config, status capture, interrupts and counters
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prdata          <= 32'h0;
            pready          <= 1'b0;
            pslverr         <= 1'b0;
            start           <= 1'b0;
            soft_reset      <= 1'b0;
            activation_type <= 2'd0;
            matrix_size     <= 8'(MATRIX_SIZE);
            irq             <= 1'b0;
            busy_q          <= 1'b0;
            err_q           <= 1'b0;
            cs_q            <= 3'd0;
            done_seen       <= 1'b0;
            int_en          <= 3'd0;
            int_stat        <= 3'd0;
            cyc_cnt         <= 32'h0;
            run_cnt         <= 16'h0;
        end else begin
            if (setup) prdata <= rd;
            pready     <= setup;
            pslverr    <= setup && bad;
            start      <= st_issue;
            soft_reset <= soft_wr;
            if (wr && sel == 3'd1) {activation_type, matrix_size} <= pwdata[9:0];
            if (wr && sel == 3'd3) int_en <= pwdata[2:0];
            busy_q    <= busy;
            err_q     <= error;
            cs_q      <= current_state;
            done_seen <= soft_wr ? 1'b0 : done ? 1'b1 : st_issue ? 1'b0 : done_seen;
            int_stat  <= soft_wr ? 3'd0 : (int_stat & ~w1c) | {ovr, err_rise, done};
            irq       <= soft_wr ? 1'b0 : |(int_stat & int_en);
            cyc_cnt   <= (soft_wr || st_issue) ? 32'h0 : (busy && cyc_cnt != '1) ? cyc_cnt + 32'd1 : cyc_cnt;
            run_cnt   <= (done && run_cnt != '1) ? run_cnt + 16'd1 : run_cnt;
        end
    end
endmodule

// File: tb/tb_npu_reg_ctrl.sv
// tb_npu_reg_ctrl: scoreboard bench for the NPU register front-end
module tb_npu_reg_ctrl;
    logic        clk = 0, rst_n = 0, psel = 0, penable = 0, pwrite = 0;
    logic [7:0]  paddr = 0;
    logic [31:0] pwdata = 0, prdata;
    logic        pready, pslverr, start, soft_reset, irq;
    logic [1:0]  activation_type;
    logic [7:0]  matrix_size;
    logic        busy = 0, done = 0, error = 0;
    logic [2:0]  current_state = 3'd5;
    int          n_chk = 0, n_fail = 0;
    logic [33:0] exp_q[$];
    string       name_q[$];

    npu_reg_ctrl #(.MATRIX_SIZE(8), .ADDR_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr),
        .start(start), .soft_reset(soft_reset), .activation_type(activation_type),
        .matrix_size(matrix_size), .busy(busy), .done(done), .error(error),
        .current_state(current_state), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // Monitor: every completed transfer is matched against the oldest expectation
    always @(negedge clk) begin
        if (pready) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_pready: got pready=1 expected no transfer");
            end else begin
                logic [33:0] e;
                string nm;
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                chk({nm, "_pslverr"}, {31'h0, pslverr}, {31'h0, e[0]});
                if (e[33]) chk({nm, "_prdata"}, prdata, e[32:1]);
            end
        end
    end

    task automatic apb(input logic w, input logic [7:0] a, input logic [31:0] d,
                       input logic chk_d, input logic [31:0] exp_d, input logic exp_e,
                       input string nm, input logic dpulse);
        @(negedge clk);
        psel = 1; penable = 0; pwrite = w; paddr = a; pwdata = d;
        exp_q.push_back({chk_d, exp_d, exp_e});
        name_q.push_back(nm);
        @(negedge clk);
        penable = 1;
        if (dpulse) done = 1;
        @(negedge clk);
        psel = 0; penable = 0; pwrite = 0;
        if (dpulse) done = 0;
    endtask

    task automatic rd(input logic [7:0] a, input logic [31:0] e, input string nm);
        apb(0, a, 0, 1, e, 0, nm, 0);
    endtask
    task automatic wr(input logic [7:0] a, input logic [31:0] d, input string nm);
        apb(1, a, d, 0, 0, 0, nm, 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        chk("rst_prdata", prdata, 0);
        chk("rst_pready", {31'h0, pready}, 0);
        chk("rst_pslverr", {31'h0, pslverr}, 0);
        chk("rst_start", {31'h0, start}, 0);
        chk("rst_soft", {31'h0, soft_reset}, 0);
        chk("rst_irq", {31'h0, irq}, 0);
        chk("rst_msize", {24'h0, matrix_size}, 8);
        chk("rst_act", {30'h0, activation_type}, 0);
        rd(8'h04, 32'h8, "rd_config_rst");
        rd(8'h00, 32'h0, "rd_ctrl");
        rd(8'h18, 32'h0, "rd_run_rst");
        wr(8'h04, 32'h205, "wr_config");
        chk("cfg_act", {30'h0, activation_type}, 2);
        chk("cfg_msize", {24'h0, matrix_size}, 5);
        wr(8'h00, 32'h1, "wr_start");
        chk("start_pulse", {31'h0, start}, 1);
        @(negedge clk);
        chk("start_one_cycle", {31'h0, start}, 0);
        rd(8'h14, 32'h0, "rd_cyc_zero");
        wr(8'h0C, 32'h1, "wr_inten_done");
        busy = 1;
        repeat (37) @(negedge clk);
        busy = 0; done = 1;
        @(negedge clk);
        done = 0;
        chk("irq_latency", {31'h0, irq}, 0);
        @(negedge clk);
        chk("irq_done", {31'h0, irq}, 1);
        rd(8'h14, 32'd37, "rd_cyc37");
        rd(8'h18, 32'd1, "rd_run1");
        rd(8'h10, 32'h1, "rd_intstat_done");
        rd(8'h08, 32'h52, "rd_status_done");
        wr(8'h10, 32'h1, "w1c_done");
        @(negedge clk);
        chk("irq_cleared", {31'h0, irq}, 0);
        rd(8'h10, 32'h0, "rd_intstat_clr");
        busy = 1;
        wr(8'h00, 32'h1, "wr_start_busy");
        chk("no_start_busy", {31'h0, start}, 0);
        @(negedge clk);
        chk("no_start_busy2", {31'h0, start}, 0);
        busy = 0;
        rd(8'h10, 32'h4, "rd_overrun");
        apb(1, 8'h10, 32'h1, 0, 0, 0, "w1c_vs_done", 1);
        rd(8'h10, 32'h5, "rd_set_wins");
        rd(8'h18, 32'd2, "rd_run2");
        wr(8'h10, 32'h7, "w1c_all");
        rd(8'h10, 32'h0, "rd_intstat_zero");
        wr(8'h0C, 32'h3, "wr_inten_err");
        error = 1;
        @(negedge clk);
        chk("irq_err_latency", {31'h0, irq}, 0);
        @(negedge clk);
        chk("irq_err", {31'h0, irq}, 1);
        rd(8'h10, 32'h2, "rd_intstat_err");
        rd(8'h08, 32'h56, "rd_status_err");
        wr(8'h00, 32'h3, "wr_soft_start");
        chk("soft_pulse", {31'h0, soft_reset}, 1);
        chk("soft_no_start", {31'h0, start}, 0);
        chk("soft_irq", {31'h0, irq}, 0);
        @(negedge clk);
        chk("soft_one_cycle", {31'h0, soft_reset}, 0);
        chk("soft_irq2", {31'h0, irq}, 0);
        rd(8'h10, 32'h0, "rd_intstat_soft");
        rd(8'h04, 32'h205, "rd_config_kept");
        rd(8'h0C, 32'h3, "rd_inten_kept");
        rd(8'h18, 32'd2, "rd_run_kept");
        rd(8'h14, 32'h0, "rd_cyc_soft");
        rd(8'h08, 32'h54, "rd_status_soft");
        apb(0, 8'h3C, 0, 1, 0, 1, "rd_unmapped", 0);
        apb(1, 8'h08, 32'hFF, 0, 0, 1, "wr_status_ro", 0);
        apb(1, 8'h14, 32'h1234, 0, 0, 1, "wr_cyc_ro", 0);
        apb(1, 8'h40, 32'h3, 0, 0, 1, "wr_unmapped", 0);
        apb(1, 8'h1C, 32'h1, 0, 0, 1, "wr_hole", 0);
        rd(8'h08, 32'h54, "rd_status_unchanged");
        rd(8'h14, 32'h0, "rd_cyc_unchanged");
        rd(8'h04, 32'h205, "rd_config_unchanged");
        // Reset asserted across a transfer: nothing must commit
        @(negedge clk);
        psel = 1; penable = 0; pwrite = 1; paddr = 8'h00; pwdata = 32'h1; rst_n = 0;
        @(negedge clk);
        penable = 1;
        @(negedge clk);
        psel = 0; penable = 0; pwrite = 0;
        chk("midrst_start", {31'h0, start}, 0);
        chk("midrst_pready", {31'h0, pready}, 0);
        chk("midrst_msize", {24'h0, matrix_size}, 8);
        rst_n = 1;
        error = 0;
        @(negedge clk);
        rd(8'h18, 32'h0, "rd_run_after_rst");
        rd(8'h0C, 32'h0, "rd_inten_after_rst");
        repeat (3) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
